// File: rtl/packet_slot_store.sv
// Serial frame assembler with masked known-field check and an ID-keyed slot store.
// Accepted frames land in a matching, free or round-robin-replaced slot; readout is byte-addressed and registered.
module packet_slot_store #(
    parameter int FRAME_BITS = 192,
    parameter int SLOTS      = 4,
    parameter logic [FRAME_BITS-1:0] KNOWN_MASK  = {{96{1'b1}}, {96{1'b0}}},
    parameter logic [FRAME_BITS-1:0] KNOWN_VALUE =
        {32'hAAAAAAAA, 16'hD391, 16'hD391, 32'h0DFFFFFE, 96'h0},
    parameter int ID_LSB     = 64,
    parameter int ID_WIDTH   = 32,
    parameter int NBYTES     = FRAME_BITS / 8,
    parameter int SLOT_W     = $clog2(SLOTS),
    parameter int BYTE_W     = $clog2(NBYTES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_begin,
    input  logic              bit_valid,
    input  logic              bit_data,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [BYTE_W-1:0] rd_byte,
    input  logic              rd_ack,
    output logic [7:0]        rd_data,
    output logic              rd_new,
    output logic [SLOTS-1:0]  slot_occupied,
    output logic              frame_valid,
    output logic              frame_reject,
    output logic [SLOT_W-1:0] slot_written,
    output logic [7:0]        valid_count,
    output logic [7:0]        reject_count
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FRAME_BITS);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(SLOTS - 1);

    logic [FRAME_BITS-1:0] frame;
    logic [CNT_W-1:0]      bit_count;
    logic                  eval_pend;

    logic [FRAME_BITS-1:0] slot_data [SLOTS];
    logic [SLOTS-1:0]      new_flag;
    logic [SLOT_W-1:0]     replace_ptr;

    logic                  frame_ok;
    logic                  hit, have_free, use_ptr;
    logic [SLOT_W-1:0]     hit_idx, free_idx, target;
    logic [FRAME_BITS-1:0] rd_frame;
    logic [7:0]            rd_byte_val;

    // eval_pend marks the single cycle after the count first reaches FRAME_BITS
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame     <= '0;
            bit_count <= '0;
            eval_pend <= 1'b0;
        end else begin
            eval_pend <= 1'b0;
            if (frame_begin) begin
                bit_count <= bit_valid ? CNT_W'(1) : '0;
                if (bit_valid) frame <= {frame[FRAME_BITS-2:0], bit_data};
            end else if (bit_valid && bit_count != FULL_COUNT) begin
                frame     <= {frame[FRAME_BITS-2:0], bit_data};
                bit_count <= bit_count + 1'b1;
                if (bit_count == FULL_COUNT - 1'b1) eval_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        frame_ok  = ((frame ^ KNOWN_VALUE) & KNOWN_MASK) == '0;
        hit       = 1'b0;
        hit_idx   = '0;
        have_free = 1'b0;
        free_idx  = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!hit && slot_occupied[i] &&
                slot_data[i][ID_LSB +: ID_WIDTH] == frame[ID_LSB +: ID_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
            if (!have_free && !slot_occupied[i]) begin
                have_free = 1'b1;
                free_idx  = SLOT_W'(i);
            end
        end
        use_ptr = !hit && !have_free;
        target  = hit ? hit_idx : (have_free ? free_idx : replace_ptr);
    end

    // The accept write to new_flag follows the ack clear, so a same-cycle write wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) slot_data[i] <= '0;
            slot_occupied <= '0;
            new_flag      <= '0;
            replace_ptr   <= '0;
            frame_valid   <= 1'b0;
            frame_reject  <= 1'b0;
            slot_written  <= '0;
            valid_count   <= '0;
            reject_count  <= '0;
        end else begin
            frame_valid  <= 1'b0;
            frame_reject <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                if (rd_ack && rd_slot == SLOT_W'(i)) new_flag[i] <= 1'b0;
            end
            if (eval_pend) begin
                if (frame_ok) begin
                    frame_valid           <= 1'b1;
                    slot_data[target]     <= frame;
                    slot_occupied[target] <= 1'b1;
                    new_flag[target]      <= 1'b1;
                    slot_written          <= target;
                    if (valid_count != 8'hFF) valid_count <= valid_count + 1'b1;
                    if (use_ptr) replace_ptr <= (replace_ptr == LAST_SLOT) ? '0 : replace_ptr + 1'b1;
                end else begin
                    frame_reject <= 1'b1;
                    if (reject_count != 8'hFF) reject_count <= reject_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_frame = '0;
        rd_new   = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (rd_slot == SLOT_W'(i)) begin
                rd_new = new_flag[i];
                if (slot_occupied[i]) rd_frame = slot_data[i];
            end
        end
        rd_byte_val = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (rd_byte == BYTE_W'(k)) rd_byte_val = rd_frame[8*k +: 8];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= rd_byte_val;
    end

endmodule

// File: tb/tb_packet_slot_store.sv
// Directed + randomized bench for packet_slot_store against an array-based slot-store model.
module tb_packet_slot_store;

    localparam int NS = 4;
    localparam logic [191:0] KM = {{96{1'b1}}, {96{1'b0}}};
    localparam logic [191:0] KV = {32'hAAAAAAAA, 16'hD391, 16'hD391, 32'h0DFFFFFE, 96'h0};

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_begin, bit_valid, bit_data, rd_ack;
    logic [1:0] rd_slot;
    logic [4:0] rd_byte;
    logic [7:0] rd_data, valid_count, reject_count;
    logic       rd_new, frame_valid, frame_reject;
    logic [3:0] slot_occupied;
    logic [1:0] slot_written;

    packet_slot_store #(.FRAME_BITS(192), .SLOTS(4), .ID_LSB(64), .ID_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .frame_begin(frame_begin), .bit_valid(bit_valid),
        .bit_data(bit_data), .rd_slot(rd_slot), .rd_byte(rd_byte), .rd_ack(rd_ack),
        .rd_data(rd_data), .rd_new(rd_new), .slot_occupied(slot_occupied),
        .frame_valid(frame_valid), .frame_reject(frame_reject), .slot_written(slot_written),
        .valid_count(valid_count), .reject_count(reject_count)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [191:0] m_slot [NS];
    bit           m_occ  [NS];
    bit           m_new  [NS];
    int           m_ptr, m_vcnt, m_rcnt, m_written;
    int           ev_valid = 0, ev_reject = 0;
    int           seen_valid = 0, seen_reject = 0;

    always @(negedge clock) begin
        if (frame_valid)  seen_valid++;
        if (frame_reject) seen_reject++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] mk(input logic [31:0] id, input logic [63:0] lo);
        return {32'hAAAAAAAA, 16'hD391, 16'hD391, 32'h0DFFFFFE, id, lo};
    endfunction

    function automatic logic [3:0] occ_vec();
        logic [3:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_occ[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_slot[i] = '0; m_occ[i] = 0; m_new[i] = 0;
        end
        m_ptr = 0; m_vcnt = 0; m_rcnt = 0; m_written = 0;
    endtask

    // Evaluate a completed frame by the storage rules and return whether it was accepted.
    task automatic model_eval(input logic [191:0] f, input bit ack, input int ack_slot, output bit ok);
        int tgt;
        if (ack) m_new[ack_slot] = 0;
        ok = ((f & KM) == (KV & KM));
        if (!ok) begin
            ev_reject++;
            if (m_rcnt < 255) m_rcnt++;
            return;
        end
        ev_valid++;
        if (m_vcnt < 255) m_vcnt++;
        tgt = -1;
        for (int i = 0; i < NS; i++)
            if (tgt < 0 && m_occ[i] && m_slot[i][95:64] == f[95:64]) tgt = i;
        for (int i = 0; i < NS; i++)
            if (tgt < 0 && !m_occ[i]) tgt = i;
        if (tgt < 0) begin
            tgt   = m_ptr;
            m_ptr = (m_ptr + 1) % NS;
        end
        m_slot[tgt] = f; m_occ[tgt] = 1; m_new[tgt] = 1; m_written = tgt;
    endtask

    task automatic eval_check(input string tag, input logic [191:0] f, input bit ack);
        bit ok;
        model_eval(f, ack, int'(rd_slot), ok);
        check({tag, ".valid"},  32'(frame_valid),   32'(ok));
        check({tag, ".reject"}, 32'(frame_reject),  32'(!ok));
        check({tag, ".vcnt"},   32'(valid_count),   32'(m_vcnt));
        check({tag, ".rcnt"},   32'(reject_count),  32'(m_rcnt));
        check({tag, ".occ"},    32'(slot_occupied), 32'(occ_vec()));
        check({tag, ".written"},32'(slot_written),  32'(m_written));
        check({tag, ".new"},    32'(rd_new),        32'(m_new[rd_slot]));
    endtask

    task automatic send_bits(input logic [191:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bit_valid = 1'b1; bit_data = f[i];
            step();
        end
        bit_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [191:0] f, input bit ack);
        frame_begin = 1'b1;
        step();
        frame_begin = 1'b0;
        send_bits(f, 191, 0);
        rd_ack = ack;
        step();
        rd_ack = 1'b0;
        eval_check(tag, f, ack);
        step();
        check({tag, ".pulse_end"}, 32'({frame_valid, frame_reject}), 32'd0);
    endtask

    task automatic check_read(input string tag, input int s, input int b);
        logic [7:0] e;
        rd_slot = 2'(s); rd_byte = 5'(b);
        step();
        e = m_occ[s] ? m_slot[s][8*b +: 8] : 8'h00;
        check({tag, ".rd_data"}, 32'(rd_data), 32'(e));
        check({tag, ".rd_new"},  32'(rd_new),  32'(m_new[s]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".rd_data"}, 32'(rd_data),       32'd0);
        check({tag, ".rd_new"},  32'(rd_new),        32'd0);
        check({tag, ".occ"},     32'(slot_occupied), 32'd0);
        check({tag, ".pulses"},  32'({frame_valid, frame_reject}), 32'd0);
        check({tag, ".written"}, 32'(slot_written),  32'd0);
        check({tag, ".counts"},  32'({valid_count, reject_count}), 32'd0);
    endtask

    initial begin
        logic [191:0] f;
        logic [31:0]  ids [6];
        reset = 1'b1; frame_begin = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
        rd_ack = 1'b0; rd_slot = '0; rd_byte = '0;
        model_reset();
        step(); step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // First valid frame lands in slot 0; byte 8 is the ID's low byte
        run_frame("first", mk(32'h12345678, 64'h4C4C_0000_0000_0011), 1'b0);
        check("first.slot", 32'(slot_written), 32'd0);
        check_read("first_b8", 0, 8);
        check("first.b8val", 32'(rd_data), 32'h78);
        check_read("first_b6", 0, 6);

        // Same ID rewrites slot 0
        run_frame("resend", mk(32'h12345678, 64'h4C4C_0000_0000_0022), 1'b0);
        check_read("resend_b0", 0, 0);
        check("resend.b0val", 32'(rd_data), 32'h22);
        check("resend.occ1", 32'(slot_occupied), 32'h1);

        // Fill, then replace round-robin
        ids = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 32'hE5E5E5E5, 32'hF6F6F6F6};
        for (int i = 0; i < 5; i++) run_frame("fill", mk(ids[i], {ids[i], 32'h0}), 1'b0);
        check("replace5.slot", 32'(slot_written), 32'd1);
        check_read("after_fill_s0", 0, 8);
        check("replace4.id", 32'(rd_data), 32'hD4);
        for (int s = 0; s < NS; s++) check_read("fill_rd", s, 4);

        // rd_ack coinciding with a write to slot 0 keeps new set; ack alone clears it
        rd_slot = 2'd0;
        run_frame("ack_write", mk(32'hD4D4D4D4, 64'h55), 1'b1);
        check("ack_write.new", 32'(rd_new), 32'd1);
        rd_ack = 1'b1; step(); rd_ack = 1'b0;
        m_new[0] = 0;
        check("ack_alone.new", 32'(rd_new), 32'd0);

        // Corrupted preamble is rejected and leaves slots alone
        f = mk(32'hD4D4D4D4, 64'h99);
        f[191:160] = 32'hAAAAAAAB;
        run_frame("corrupt", f, 1'b0);
        for (int s = 0; s < NS; s++) check_read("corrupt_rd", s, 0);

        // Restart after 100 bits, new first bit in the same cycle, then extra bits ignored
        frame_begin = 1'b1; step(); frame_begin = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bit_valid = 1'b1; bit_data = 1'($urandom); step();
        end
        f = mk(32'h0BADCAFE, {$urandom, $urandom});
        frame_begin = 1'b1; bit_valid = 1'b1; bit_data = f[191]; step();
        frame_begin = 1'b0;
        send_bits(f, 190, 0);
        bit_valid = 1'b1; bit_data = ~f[0];
        step();
        eval_check("restart", f, 1'b0);
        for (int i = 0; i < 9; i++) begin
            bit_data = 1'($urandom); step();
        end
        bit_valid = 1'b0;
        check_read("restart_b0", m_written, 0);
        check_read("restart_b10", m_written, 10);

        // Randomized frames from a small ID pool
        for (int n = 0; n < 24; n++) begin
            f = mk(32'hC0DE0000 + 32'($urandom_range(0, 7)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) f[96 + $urandom_range(0, 95)] ^= 1'b1;
            rd_slot = 2'($urandom_range(0, 3));
            run_frame("rand", f, 1'($urandom_range(0, 1)));
            check_read("rand_rd", $urandom_range(0, 3), $urandom_range(0, 23));
        end

        // Reject counter saturation
        for (int n = 0; n < 300; n++) begin
            f = mk(32'($urandom), {$urandom, $urandom});
            f[96 + $urandom_range(0, 95)] ^= 1'b1;
            run_frame("sat", f, 1'b0);
        end
        check("sat.rcnt255", 32'(reject_count), 32'd255);

        // Reset during bit 150 discards the frame, no pulse follows
        f = mk(32'h12345678, 64'h1);
        frame_begin = 1'b1; step(); frame_begin = 1'b0;
        send_bits(f, 191, 43);
        bit_valid = 1'b1; bit_data = f[42];
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_zero("midreset");
        step(); step();
        reset = 1'b0;
        send_bits(f, 41, 0);
        step(); step(); step();
        check_zero("post_reset");
        check("pulses.valid",  32'(seen_valid),  32'(ev_valid));
        check("pulses.reject", 32'(seen_reject), 32'(ev_reject));

        run_frame("after_reset", mk(32'h77777777, 64'h42), 1'b0);
        check_read("after_reset_b0", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
